// File: rtl/hi_fanout_monitor.sv
// hi_fanout_monitor
// Observer for a high-fanout register tree. It delays the driver's D input
// by LATENCY cycles and compares the result against every load flop Q over
// a programmed window of cycles. It reports a sticky error flag, a saturating
// count of mismatching cycles, and the lowest failing load index and the
// compare cycle of the first mismatch in the run.
module hi_fanout_monitor #(
    parameter int NUM_LOADS = 70,
    parameter int LATENCY   = 2,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = 7
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     window,
    input  logic                 in,
    input  logic [NUM_LOADS-1:0] loads,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [IDX_W-1:0]     first_idx,
    output logic [CNT_W-1:0]     first_cyc
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ARM counts 0 .. LATENCY-2, so $clog2(LATENCY) bits are enough.
    localparam int ARM_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    logic [1:0]           state_q,     state_d;
    logic [CNT_W-1:0]     win_q,       win_d;
    logic [CNT_W-1:0]     cmp_cnt_q,   cmp_cnt_d;
    logic [ARM_W-1:0]     arm_cnt_q,   arm_cnt_d;
    logic [LATENCY-1:0]   dly_q,       dly_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 err_q,       err_d;
    logic [CNT_W-1:0]     err_cnt_q,   err_cnt_d;
    logic [IDX_W-1:0]     first_idx_q, first_idx_d;
    logic [CNT_W-1:0]     first_cyc_q, first_cyc_d;

    logic                 expected;
    logic [NUM_LOADS-1:0] diff;
    logic                 mismatch;
    logic [IDX_W-1:0]     low_idx;
    logic                 arm_last;
    logic                 cmp_last;

    assign expected = dly_q[LATENCY-1];
    assign diff     = loads ^ {NUM_LOADS{expected}};
    assign mismatch = |diff;
    assign arm_last = (int'(arm_cnt_q) == LATENCY - 2);
    assign cmp_last = (cmp_cnt_q == win_q - CNT_W'(1));

    // Delay line of the driver input, shifting every cycle regardless of state.
    always_comb begin
        dly_d[0] = in;
        for (int i = 1; i < LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Lowest set bit of the mismatch vector; scanning downward leaves the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_LOADS - 1; i >= 0; i--) begin
            if (diff[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Control FSM, window counters and result bookkeeping.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        win_d       = win_q;
        cmp_cnt_d   = cmp_cnt_q;
        arm_cnt_d   = arm_cnt_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        first_cyc_d = first_cyc_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    win_d       = window;
                    cmp_cnt_d   = '0;
                    arm_cnt_d   = '0;
                    err_d       = 1'b0;
                    err_cnt_d   = '0;
                    first_idx_d = '0;
                    first_cyc_d = '0;
                    if (window == '0) begin
                        state_d = ST_DONE;
                    end else if (LATENCY == 1) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end

            ST_ARM: begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
                if (arm_last) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
                if (mismatch) begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        first_idx_d = low_idx;
                        first_cyc_d = cmp_cnt_q;
                    end
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                if (cmp_last) begin
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ARM) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State registers with synchronous reset; rst overrides any start.
    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            cmp_cnt_q   <= '0;
            arm_cnt_q   <= '0;
            // NOTE: the delay line is a handful of flops and must read as cleared after rst, so it is reset too.
            dly_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_cyc_q <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cmp_cnt_q   <= cmp_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            dly_q       <= dly_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            first_cyc_q <= first_cyc_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign first_idx = first_idx_q;
    assign first_cyc = first_cyc_q;

endmodule

// File: tb/tb_hi_fanout_monitor.sv
// Bench for hi_fanout_monitor. The loads are driven as the driver input
// delayed by LATENCY, with optional bit inversions. The expected outputs
// come from a run record (start cycle, window) and the recorded input and
// load history, evaluated with the block's timing rules.
module tb_hi_fanout_monitor;

    localparam int NL   = 70;
    localparam int LAT  = 2;
    localparam int CW   = 16;
    localparam int IW   = 7;
    localparam int HIST = 4096;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] window;
    logic          in;
    logic [NL-1:0] loads;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] err_cnt;
    logic [IW-1:0] first_idx;
    logic [CW-1:0] first_cyc;

    hi_fanout_monitor #(
        .NUM_LOADS (NL),
        .LATENCY   (LAT),
        .CNT_W     (CW),
        .IDX_W     (IW)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .start     (start),
        .window    (window),
        .in        (in),
        .loads     (loads),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt),
        .first_idx (first_idx),
        .first_cyc (first_cyc)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit            in_hist    [HIST];
    logic [NL-1:0] loads_hist [HIST];

    // Current run as seen by the reference: accepted start cycle and window.
    bit have_run = 1'b0;
    int run_s    = 0;
    int run_w    = 0;

    // Directed fault injection relative to the current run's first compare cycle.
    int            fa_k = -100;
    int            fb_k = -100;
    logic [NL-1:0] fa_m = '0;
    logic [NL-1:0] fb_m = '0;

    function automatic int done_cycle();
        return (run_w == 0) ? run_s + 1 : run_s + LAT + run_w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Evaluate every output for the current cycle from the run record and history.
    task automatic check_model();
        bit            e_busy = 1'b0;
        bit            e_done = 1'b0;
        bit            e_err  = 1'b0;
        int            e_cnt  = 0;
        int            e_idx  = 0;
        int            e_cyc  = 0;
        logic [NL-1:0] d;
        if (have_run) begin
            e_busy = (run_w != 0) && (cyc >= run_s + 1) && (cyc <= run_s + LAT + run_w - 1);
            e_done = (cyc >= done_cycle());
            for (int t = run_s + LAT; (t <= run_s + LAT + run_w - 1) && (t <= cyc - 1); t++) begin
                d = loads_hist[t] ^ {NL{in_hist[t-LAT]}};
                if (d != '0) begin
                    if (!e_err) begin
                        e_cyc = t - (run_s + LAT);
                        for (int b = NL - 1; b >= 0; b--) begin
                            if (d[b]) e_idx = b;
                        end
                    end
                    e_err = 1'b1;
                    if (e_cnt < (1 << CW) - 1) e_cnt++;
                end
            end
        end
        chk("busy",      32'(busy),      32'(e_busy));
        chk("done",      32'(done),      32'(e_done));
        chk("err",       32'(err),       32'(e_err));
        chk("err_cnt",   32'(err_cnt),   32'(e_cnt));
        chk("first_idx", 32'(first_idx), 32'(e_idx));
        chk("first_cyc", 32'(first_cyc), 32'(e_cyc));
    endtask

    // One clock cycle: drive inputs, update the run record, then check after the edge.
    task automatic step(input bit r, input bit st, input logic [CW-1:0] w, input logic [NL-1:0] extra);
        logic [NL-1:0] m;
        logic          b;
        m = extra;
        b = 1'($urandom);
        if (have_run && cyc == run_s + LAT + fa_k) m = m ^ fa_m;
        if (have_run && cyc == run_s + LAT + fb_k) m = m ^ fb_m;
        in_hist[cyc]    = b;
        loads_hist[cyc] = ((cyc >= LAT) ? {NL{in_hist[cyc-LAT]}} : '0) ^ m;
        rst    = r;
        start  = st;
        window = w;
        in     = b;
        loads  = loads_hist[cyc];
        if (r) begin
            have_run = 1'b0;
        end else if (st && (!have_run || cyc >= done_cycle())) begin
            have_run = 1'b1;
            run_s    = cyc;
            run_w    = int'(w);
        end
        @(posedge clk1);
        #1;
        cyc++;
        check_model();
    endtask

    // Window-10 run from start; checks done stays low at S+11 and rises at S+12.
    task automatic run_w10(input string tag);
        step(1'b0, 1'b1, 16'd10, '0);
        repeat (10) step(1'b0, 1'b0, 16'd0, '0);
        chk({tag, "_done_pre"}, 32'(done), 32'd0);
        chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
        step(1'b0, 1'b0, 16'd0, '0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        window = '0;
        in     = 1'b0;
        loads  = '0;

        // Reset held two cycles with random inputs.
        repeat (2) step(1'b1, 1'($urandom), CW'($urandom), NL'($urandom));
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        step(1'b0, 1'b0, 16'd0, '0);

        // Clean run.
        run_w10("clean");
        chk("clean_err",       32'(err),       32'd0);
        chk("clean_err_cnt",   32'(err_cnt),   32'd0);
        chk("clean_first_idx", 32'(first_idx), 32'd0);
        chk("clean_first_cyc", 32'(first_cyc), 32'd0);

        // Single fault: load 37 inverted in compare cycle 4.
        fa_k = 4;
        fa_m = NL'(1) << 37;
        run_w10("single");
        chk("single_err",       32'(err),       32'd1);
        chk("single_err_cnt",   32'(err_cnt),   32'd1);
        chk("single_first_idx", 32'(first_idx), 32'd37);
        chk("single_first_cyc", 32'(first_cyc), 32'd4);

        // New start from DONE clears results; then multiple faults.
        fa_k = 2;
        fa_m = (NL'(1) << 60) | (NL'(1) << 5);
        fb_k = 7;
        fb_m = NL'(1) << 1;
        step(1'b0, 1'b1, 16'd10, '0);
        chk("restart_err",       32'(err),       32'd0);
        chk("restart_err_cnt",   32'(err_cnt),   32'd0);
        chk("restart_first_idx", 32'(first_idx), 32'd0);
        repeat (11) step(1'b0, 1'b0, 16'd0, '0);
        chk("multi_done",      32'(done),      32'd1);
        chk("multi_err_cnt",   32'(err_cnt),   32'd2);
        chk("multi_first_idx", 32'(first_idx), 32'd5);
        chk("multi_first_cyc", 32'(first_cyc), 32'd2);
        fa_k = -100;
        fb_k = -100;

        // Zero window from IDLE: DONE on the next cycle with empty results.
        step(1'b1, 1'b0, 16'd0, '0);
        step(1'b0, 1'b1, 16'd0, '0);
        chk("w0_done",    32'(done),    32'd1);
        chk("w0_busy",    32'(busy),    32'd0);
        chk("w0_err_cnt", 32'(err_cnt), 32'd0);
        step(1'b0, 1'b0, 16'd0, '0);

        // start re-pulsed mid-CHECK and in the last CHECK cycle is ignored.
        step(1'b0, 1'b1, 16'd10, '0);
        repeat (4) step(1'b0, 1'b0, 16'd0, '0);
        step(1'b0, 1'b1, 16'd3, '0);
        repeat (5) step(1'b0, 1'b0, 16'd0, '0);
        chk("repulse_done_pre", 32'(done), 32'd0);
        step(1'b0, 1'b1, 16'd5, '0);
        chk("repulse_done", 32'(done), 32'd1);
        chk("repulse_busy", 32'(busy), 32'd0);

        // Reset in compare cycle 5 after a fault in compare cycle 2.
        fa_k = 2;
        fa_m = NL'(1) << 20;
        step(1'b0, 1'b1, 16'd10, '0);
        repeat (6) step(1'b0, 1'b0, 16'd0, '0);
        chk("midrst_err_before", 32'(err), 32'd1);
        step(1'b1, 1'b1, 16'd10, '0);
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_done",    32'(done),    32'd0);
        chk("midrst_err",     32'(err),     32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        fa_k = -100;
        step(1'b0, 1'b0, 16'd0, '0);
        run_w10("post_rst");
        chk("post_rst_err", 32'(err), 32'd0);

        // Random traffic: random starts, windows, inverted bits and rare resets.
        for (int i = 0; i < 600; i++) begin
            logic [NL-1:0] m;
            m = '0;
            if ($urandom_range(4) == 0) m[$urandom_range(NL - 1)] = 1'b1;
            if ($urandom_range(9) == 0) m[$urandom_range(NL - 1)] = 1'b1;
            step($urandom_range(149) == 0, $urandom_range(5) == 0, CW'($urandom_range(12)), m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hi_fanout_monitor.md
# hi_fanout_monitor

Self-checking capture stage that sits directly downstream of the hierarchical high-fanout register. That stage is one driver flop broadcasting to `NUM_LOADS` load flops spread across child instances. This block samples the bit fed into the driver and compares it, `LATENCY` cycles later, against the Q outputs of every load flop. It counts mismatching cycles over a programmed window and reports which load failed first. It gives the team an in-design observer for confirming that buffering or fanout repair preserves logical behaviour on every branch.

## Interface
- `NUM_LOADS`, default 70: number of load-flop outputs observed.
- `LATENCY`, default 2: cycles from `in` to load Q (driver flop plus load flop). Must be ≥1.
- `CNT_W`, default 16: width of `window`, the cycle counters and `err_cnt`.
- `IDX_W`, default 7: width of `first_idx`. Must satisfy 2^IDX_W ≥ `NUM_LOADS`.

Ports:
- `clk1`, input, 1: the single clock, rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request to begin a check window.
- `window`, input, `CNT_W`: number of compare cycles. Latched when `start` is accepted.
- `in`, input, 1: the bit presented to the driver flop's D input.
- `loads`, input, `NUM_LOADS`: Q outputs of the load flops.
- `busy`, output, 1: high in ARM or CHECK.
- `done`, output, 1: high in DONE, held until the next accepted `start`.
- `err`, output, 1: sticky flag, set on any mismatch in the current run.
- `err_cnt`, output, `CNT_W`: count of mismatching compare cycles, saturating at 2^CNT_W−1.
- `first_idx`, output, `IDX_W`: lowest mismatching load index in the first mismatching cycle.
- `first_cyc`, output, `CNT_W`: 0-based compare-cycle number of the first mismatch.

## Operation
- Delay line: a `LATENCY`-deep shift register of `in`, shifting every cycle in every state. Cleared by `rst`.
- Expected value at cycle t: the `in` sampled at cycle t−`LATENCY`.
- Mismatch at cycle t: any bit of `loads` ≠ expected value.
- State machine:
  - IDLE → ARM on `start`. Cleared on accept: `err`, `err_cnt`, `first_idx`, `first_cyc`, compare counter. `window` is latched.
  - ARM lasts `LATENCY`−1 cycles, then → CHECK. With `LATENCY`=1, ARM is skipped and the block enters CHECK directly.
  - CHECK compares every cycle. After the latched `window` compares → DONE.
  - DONE → ARM on `start`, with the same clears as IDLE.
- `start` is ignored in ARM and CHECK.
- `start` with `window`=0 goes directly to DONE on the next cycle, with all results 0.
- On the first mismatch of a run:
  - `err` is set.
  - `first_cyc` takes the current compare-cycle number.
  - `first_idx` takes the index of the lowest set bit of (`loads` XOR replicated expected).
  - Later mismatches in the same run do not change `first_idx` or `first_cyc`.
- `err_cnt` increments by 1 per mismatching compare cycle, regardless of how many bits mismatch. It saturates and never wraps.
- Results hold their values through DONE and IDLE until the next accepted `start`.
- `rst` at any time, including mid-CHECK:
  - Next state is IDLE.
  - All outputs go to 0.
  - The delay line is cleared.
  - The latched window is discarded.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state is IDLE.
- S is the cycle in which `start` is accepted. The `in` value sampled in cycle S is compared against `loads` in cycle S+`LATENCY`.
- `busy` is high from S+1 through S+`LATENCY`+`window`−1. That covers ARM during S+1 … S+`LATENCY`−1 and CHECK during S+`LATENCY` … S+`LATENCY`+`window`−1.
- `done` rises in cycle S+`LATENCY`+`window`, together with the falling edge of `busy`.
- A mismatch in compare cycle t is visible on `err`, `err_cnt` and `first_*` in cycle t+1. The final compare's result is therefore visible no later than the first DONE cycle.
- When `start` and `rst` are high together, `rst` wins.
- `start` asserted in the same cycle that DONE is entered is ignored: the state was still CHECK during that cycle.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs. All outputs must be 0 and `busy`=0.
- Clean run: defaults, `window`=10, random `in`, `loads` = all bits of `in` delayed 2.
  - `done` rises at S+12.
  - `err`=0, `err_cnt`=0, `first_idx`=0, `first_cyc`=0.
- Single fault: as clean run, with `loads[37]` inverted in compare cycle 4 only.
  - `err`=1, `err_cnt`=1, `first_idx`=37, `first_cyc`=4.
- Multiple faults: bits 60 and 5 inverted in compare cycle 2, and bit 1 inverted in compare cycle 7.
  - `err_cnt`=2, `first_idx`=5, `first_cyc`=2.
- Control corners:
  - `start` with `window`=0: `done`=1 at S+1, all results 0.
  - `start` re-pulsed mid-CHECK: ignored, `done` still at S+12.
  - New `start` in DONE: results clear.
- Reset mid-op: assert `rst` in compare cycle 5 after an injected fault.
  - Next cycle: IDLE, `err`=0, `err_cnt`=0, `busy`=0, `done`=0.
  - A subsequent clean run passes.
